// File: rtl/dc_pipe_if.sv
// Handshake bundle for the decode stage: upstream instruction beat,
// downstream decoded beat, and the pipeline flush.
interface dc_pipe_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rs2;
  logic [REG_W-1:0]  out_rd;
  logic [DATA_W-1:0] out_imm;
  logic [OP_W-1:0]   out_op;
  logic              out_use_rs1;
  logic              out_use_rs2;
  logic              out_illegal;

  // Instruction queue / issue side (drives instructions, consumes decodes)
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_op, out_use_rs1, out_use_rs2, out_illegal
  );

  // Decode stage side
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_op, out_use_rs1, out_use_rs2, out_illegal
  );
endinterface

// File: rtl/dc_pipe.sv
// Registered RV32I decode stage with a 2-entry skid buffer.
// Decode is done on the incoming instruction; the buffer stores decoded entries.
//
// state | meaning
// EMPTY | no entry buffered, out_valid=0
// ONE   | main register holds an entry
// TWO   | main and skid both hold entries, in_ready=0
module dc_pipe #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input logic      clk,
  input logic      rst,
  dc_pipe_if.slave bus
);

  localparam logic [OP_W-1:0]
    OP_NOP  = OP_W'(0),  OP_LUI  = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL  = OP_W'(3),
    OP_JALR = OP_W'(4),  OP_BEQ  = OP_W'(5),  OP_BNE   = OP_W'(6),  OP_BLT  = OP_W'(7),
    OP_BGE  = OP_W'(8),  OP_BLTU = OP_W'(9),  OP_BGEU  = OP_W'(10), OP_LB   = OP_W'(11),
    OP_LH   = OP_W'(12), OP_LW   = OP_W'(13), OP_LBU   = OP_W'(14), OP_LHU  = OP_W'(15),
    OP_SB   = OP_W'(16), OP_SH   = OP_W'(17), OP_SW    = OP_W'(18), OP_ADDI = OP_W'(19),
    OP_SLTI = OP_W'(20), OP_SLTIU= OP_W'(21), OP_XORI  = OP_W'(22), OP_ORI  = OP_W'(23),
    OP_ANDI = OP_W'(24), OP_SLLI = OP_W'(25), OP_SRLI  = OP_W'(26), OP_SRAI = OP_W'(27),
    OP_ADD  = OP_W'(28), OP_SUB  = OP_W'(29), OP_SLL   = OP_W'(30), OP_SLT  = OP_W'(31),
    OP_SLTU = OP_W'(32), OP_XOR  = OP_W'(33), OP_SRL   = OP_W'(34), OP_SRA  = OP_W'(35),
    OP_OR   = OP_W'(36), OP_AND  = OP_W'(37);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [OP_W-1:0]   op;
    logic              use_rs1;
    logic              use_rs2;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, dec;
  logic   load_main_in, load_main_skid, load_skid;
  logic   in_beat, out_beat;

  logic [31:0]       instr;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic              f7_ok;
  logic [REG_W-1:0]  rd_f, rs1_f, rs2_f;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  assign instr  = bus.in_instr;
  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign f7_ok  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
  assign rd_f   = REG_W'(instr[11:7]);
  assign rs1_f  = REG_W'(instr[19:15]);
  assign rs2_f  = REG_W'(instr[24:20]);
  assign imm_i  = DATA_W'($signed(instr[31:20]));
  assign imm_s  = DATA_W'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = DATA_W'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j  = DATA_W'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u  = DATA_W'({instr[31:12], 12'b0});
  assign imm_sh = DATA_W'(instr[24:20]);

  // Decode the incoming instruction; illegal encodings collapse to a flagged NOP
  always_comb begin
    dec = '0;
    case (opc)
      7'b0110111: begin dec.op = OP_LUI;   dec.rd = rd_f; dec.imm = imm_u; end
      7'b0010111: begin dec.op = OP_AUIPC; dec.rd = rd_f; dec.imm = imm_u; end
      7'b1101111: begin dec.op = OP_JAL;   dec.rd = rd_f; dec.imm = imm_j; end
      7'b1100111: begin
        dec.op = OP_JALR; dec.rd = rd_f; dec.rs1 = rs1_f; dec.use_rs1 = 1'b1; dec.imm = imm_i;
      end
      7'b1100011: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.imm = imm_b;
        case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.use_rs1 = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000:  dec.op = OP_LB;
          3'b001:  dec.op = OP_LH;
          3'b010:  dec.op = OP_LW;
          3'b100:  dec.op = OP_LBU;
          3'b101:  dec.op = OP_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.imm = imm_s;
        case (f3)
          3'b000:  dec.op = OP_SB;
          3'b001:  dec.op = OP_SH;
          3'b010:  dec.op = OP_SW;
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.use_rs1 = 1'b1; dec.imm = imm_i;
        case (f3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b111: dec.op = OP_ANDI;
          3'b001: begin dec.op = OP_SLLI; dec.imm = imm_sh; dec.illegal = !f7_ok; end
          default: begin
            dec.op = instr[30] ? OP_SRAI : OP_SRLI; dec.imm = imm_sh; dec.illegal = !f7_ok;
          end
        endcase
      end
      7'b0110011: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f;
        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.illegal = !f7_ok;
        case (f3)
          3'b000:  dec.op = instr[30] ? OP_SUB : OP_ADD;
          3'b001:  dec.op = OP_SLL;
          3'b010:  dec.op = OP_SLT;
          3'b011:  dec.op = OP_SLTU;
          3'b100:  dec.op = OP_XOR;
          3'b101:  dec.op = instr[30] ? OP_SRA : OP_SRL;
          3'b110:  dec.op = OP_OR;
          default: dec.op = OP_AND;
        endcase
      end
      7'b0001111: dec.op = OP_NOP;
      default:    dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = bus.in_pc;
  end

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign in_beat       = bus.in_valid & bus.in_ready;
  assign out_beat      = bus.out_valid & bus.out_ready;

  // Occupancy transitions and buffer load selects; flush overrides everything
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_beat) begin load_main_in = 1'b1; state_d = ONE; end
        ONE: begin
          if (in_beat && out_beat) load_main_in = 1'b1;
          else if (in_beat) begin load_skid = 1'b1; state_d = TWO; end
          else if (out_beat) state_d = EMPTY;
        end
        TWO: if (out_beat) begin load_main_skid = 1'b1; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Main and skid entry registers; zero on reset (op 0 is NOP)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= dec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  assign bus.out_pc      = main_q.pc;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_op      = main_q.op;
  assign bus.out_use_rs1 = main_q.use_rs1;
  assign bus.out_use_rs2 = main_q.use_rs2;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_dc_pipe.sv
// Directed bench for dc_pipe: expected decodes are queued at each input beat
// and compared in order at each output beat.
module tb_dc_pipe;
  localparam logic [5:0] NOP = 6'd0, LUI = 6'd1, BEQ = 6'd5, ADDI = 6'd19,
                         SLLI = 6'd25, SUB = 6'd29, SRA = 6'd35;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_pipe_if #(.PC_W(32), .DATA_W(32), .REG_W(5), .OP_W(6)) bus ();
  dc_pipe #(.PC_W(32), .DATA_W(32), .REG_W(5), .OP_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        u1;
    logic        u2;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp, prev_obs;
  logic prev_stall = 1'b0;
  int   checks = 0, passed = 0, accepts = 0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic u1, logic u2, logic ill);
    exp_t e;
    e = '{pc: 32'h0, op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm, u1: u1, u2: u2, ill: ill};
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o = '{pc: bus.out_pc, op: bus.out_op, rd: bus.out_rd, rs1: bus.out_rs1, rs2: bus.out_rs2,
          imm: bus.out_imm, u1: bus.out_use_rs1, u2: bus.out_use_rs2, ill: bus.out_illegal};
    return o;
  endfunction

  task automatic put(logic [31:0] pc, logic [31:0] instr, exp_t e);
    e.pc         = pc;
    cur_exp      = e;
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Sample the handshake one step after the falling edge, score it, then move to the next falling edge
  task automatic cycle();
    exp_t obs, e;
    #1;
    obs = observe();
    if (prev_stall) chk("hold_stable", 128'(obs), 128'(prev_obs));
    if (bus.out_valid && bus.out_ready) begin
      chk("pop_available", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("entry", 128'(obs), 128'(e));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      accepts++;
      if (!bus.flush) sb.push_back(cur_exp);
    end
    if (bus.flush) sb.delete();
    prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
    prev_obs   = obs;
    @(negedge clk);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;
    prev_obs      = '0;

    #12;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_op", 128'(bus.out_op), 128'(NOP));
    chk("rst_out_imm", 128'(bus.out_imm), 128'(0));
    chk("rst_out_rd", 128'(bus.out_rd), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single instruction latency and ADDI decode
    bus.out_ready = 1'b1;
    put(32'h100, 32'hFFF00093, mk(ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    cycle();
    idle();
    chk("latency_out_valid", 128'(bus.out_valid), 128'(1));
    cycle();
    chk("empty_after_pop", 128'(bus.out_valid), 128'(0));

    // Streaming decode patterns
    put(32'h104, 32'h402081B3, mk(SUB, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 1'b0)); cycle();
    put(32'h108, 32'h4020D1B3, mk(SRA, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 1'b0)); cycle();
    put(32'h10C, 32'hFE000EE3, mk(BEQ, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0)); cycle();
    put(32'h110, 32'h123452B7, mk(LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0, 1'b0)); cycle();
    put(32'h114, 32'h00000000, mk(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1)); cycle();
    put(32'h118, 32'h00002063, mk(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1)); cycle();
    put(32'h11C, 32'h00003003, mk(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1)); cycle();
    put(32'h120, 32'h020080B3, mk(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1)); cycle();
    put(32'h124, 32'h0000000F, mk(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0)); cycle();
    put(32'h128, 32'h01F09093, mk(SLLI, 5'd1, 5'd1, 5'd0, 32'd31, 1'b1, 1'b0, 1'b0)); cycle();
    idle(); cycle(); cycle();
    chk("stream_drained", 128'(sb.size()), 128'(0));

    // Backpressure: three offered, two taken while stalled
    bus.out_ready = 1'b0;
    accepts = 0;
    put(32'h200, 32'h00500113, mk(ADDI, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h204, 32'h00600193, mk(ADDI, 5'd3, 5'd0, 5'd0, 32'd6, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h208, 32'h00700213, mk(ADDI, 5'd4, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, 1'b0));
    chk("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
    cycle(); cycle();
    chk("bp_accepted_two", 128'(accepts), 128'(2));
    chk("bp_still_full", 128'(bus.in_ready), 128'(0));
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_in_ready_after_pop", 128'(bus.in_ready), 128'(1));
    cycle();
    idle(); cycle(); cycle();
    chk("bp_accepted_three", 128'(accepts), 128'(3));
    chk("bp_drained", 128'(sb.size()), 128'(0));

    // Flush with both entries buffered and an input offered
    bus.out_ready = 1'b0;
    put(32'h300, 32'h00500113, mk(ADDI, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h304, 32'h00600193, mk(ADDI, 5'd3, 5'd0, 5'd0, 32'd6, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h308, 32'h00700213, mk(ADDI, 5'd4, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, 1'b0));
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    idle();
    chk("flush2_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush2_in_ready", 128'(bus.in_ready), 128'(1));

    // Flush in ONE with a simultaneous input beat (dropped) and output beat (delivered)
    bus.out_ready = 1'b1;
    put(32'h310, 32'h00500113, mk(ADDI, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h314, 32'h00600193, mk(ADDI, 5'd3, 5'd0, 5'd0, 32'd6, 1'b1, 1'b0, 1'b0));
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    idle();
    chk("flush1_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush1_in_ready", 128'(bus.in_ready), 128'(1));
    put(32'h318, 32'h00700213, mk(ADDI, 5'd4, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, 1'b0)); cycle();
    idle(); cycle(); cycle();
    chk("flush_after_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_drained", 128'(sb.size()), 128'(0));

    // Asynchronous reset while holding two entries
    bus.out_ready = 1'b0;
    put(32'h400, 32'h00500113, mk(ADDI, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0)); cycle();
    put(32'h404, 32'h00600193, mk(ADDI, 5'd3, 5'd0, 5'd0, 32'd6, 1'b1, 1'b0, 1'b0)); cycle();
    idle();
    chk("pre_rst_full", 128'(bus.in_ready), 128'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("arst_out_imm", 128'(bus.out_imm), 128'(0));
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_rst_empty", 128'(bus.out_valid), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
